// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data RAM between the CPU load/store
// path and a loader/debug port. The CPU wins by default; a saturating wait
// counter force-grants the loader after MAXWAIT consecutive denied cycles.
// Read data returns one cycle after the grant and is routed by a pending tag.
module dmem_arbiter #(
  parameter int n       = 32,
  parameter int MAXWAIT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [n-1:0] cpu_addr,
  input  logic [n-1:0] cpu_wdata,
  output logic         cpu_gnt,
  output logic         cpu_rvalid,
  output logic [n-1:0] cpu_rdata,
  input  logic         ld_req,
  input  logic         ld_we,
  input  logic [n-1:0] ld_addr,
  input  logic [n-1:0] ld_wdata,
  output logic         ld_gnt,
  output logic         ld_rvalid,
  output logic [n-1:0] ld_rdata,
  output logic         ramR,
  output logic         ramW,
  output logic [n-1:0] ram_addr,
  output logic [n-1:0] ram_wdata,
  input  logic [n-1:0] ram_rdata,
  output logic [3:0]   starve_cnt
);

  // Owner of the read issued in the previous cycle, if any.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_LD   = 2'd2
  } tag_t;

  localparam logic [3:0] C_MAXWAIT = 4'(MAXWAIT);

  tag_t       r_tag;
  tag_t       w_tag_next;
  logic [3:0] r_starve;
  logic [3:0] w_starve_next;
  logic       w_sat;
  logic       w_cpu_win;
  logic       w_ld_win;

  // Arbitration: CPU first unless the loader has waited MAXWAIT cycles.
  // Reset low suppresses every grant so the RAM sees no strobe.
  always_comb begin
    w_sat     = (r_starve == C_MAXWAIT);
    w_ld_win  = reset & ld_req & (~cpu_req | w_sat);
    w_cpu_win = reset & cpu_req & ~w_ld_win;
  end

  assign cpu_gnt = w_cpu_win;
  assign ld_gnt  = w_ld_win;

  // RAM drive: winner's request is steered to the RAM, zeros when idle.
  always_comb begin
    ramR      = 1'b0;
    ramW      = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_cpu_win) begin
      ramW      = cpu_we;
      ramR      = ~cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (w_ld_win) begin
      ramW      = ld_we;
      ramR      = ~ld_we;
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
    end
  end

  // Wait counter next value: counts denied loader cycles, saturating, and
  // clears whenever the loader is served or stops asking.
  always_comb begin
    w_starve_next = r_starve;
    if (!ld_req || w_ld_win) begin
      w_starve_next = 4'd0;
    end else if (r_starve < C_MAXWAIT) begin
      w_starve_next = r_starve + 4'd1;
    end
  end

  // Pending-tag next state: records who owns the read granted this cycle.
  always_comb begin
    w_tag_next = TAG_NONE;
    if (w_cpu_win && !cpu_we) begin
      w_tag_next = TAG_CPU;
    end else if (w_ld_win && !ld_we) begin
      w_tag_next = TAG_LD;
    end
  end

  // State registers; reset drops any in-flight read response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag    <= TAG_NONE;
      r_starve <= 4'd0;
    end else begin
      r_tag    <= w_tag_next;
      r_starve <= w_starve_next;
    end
  end

  assign starve_cnt = r_starve;
  assign cpu_rvalid = (r_tag == TAG_CPU);
  assign ld_rvalid  = (r_tag == TAG_LD);
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
  assign ld_rdata   = ld_rvalid  ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural RAM answers the DUT's strobes, a
// spec-level arbitration model predicts grants, and expected read responses
// are queued at grant time and compared one cycle later.
module tb_dmem_arbiter;

  localparam int N  = 32;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [N-1:0]  cpu_addr = '0, cpu_wdata = '0;
  logic          ld_req = 1'b0, ld_we = 1'b0;
  logic [N-1:0]  ld_addr = '0, ld_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, ld_gnt, ld_rvalid, ramR, ramW;
  logic [N-1:0]  cpu_rdata, ld_rdata, ram_addr, ram_wdata;
  logic [N-1:0]  ram_rdata = '0;
  logic [3:0]    starve_cnt;

  always #5 clock = ~clock;

  dmem_arbiter #(.n(N), .MAXWAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ramR(ramR), .ramW(ramW), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .starve_cnt(starve_cnt)
  );

  // Behavioural single-port RAM, read data registered one cycle after ramR.
  logic [N-1:0] ram [0:63];
  always @(posedge clock) begin
    if (ramW) ram[ram_addr[7:2]] <= ram_wdata;
    if (ramR) ram_rdata <= ram[ram_addr[7:2]];
  end

  typedef struct {
    int           kind;   // 0 none, 1 cpu, 2 loader
    logic [N-1:0] data;
  } resp_t;

  resp_t        exp_q[$];
  logic [N-1:0] model_mem [0:63];
  int           m_starve = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc_no = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: check last cycle's response, drive new request, check
  // grant/RAM drive against the model, queue the expected response.
  task automatic cyc(input logic creq, input logic cwe, input logic [N-1:0] caddr,
                     input logic [N-1:0] cwd, input logic lreq, input logic lwe,
                     input logic [N-1:0] laddr, input logic [N-1:0] lwd,
                     output int who);
    resp_t r;
    resp_t nr;
    logic  e_cpu, e_ld;
    @(negedge clock);
    r = exp_q.pop_front();
    chk("cpu_rvalid", cpu_rvalid, r.kind == 1);
    chk("ld_rvalid",  ld_rvalid,  r.kind == 2);
    chk("cpu_rdata",  cpu_rdata,  (r.kind == 1) ? r.data : '0);
    chk("ld_rdata",   ld_rdata,   (r.kind == 2) ? r.data : '0);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    ld_req = lreq; ld_we = lwe; ld_addr = laddr; ld_wdata = lwd;
    #1;
    e_ld  = lreq && (!creq || m_starve == MW);
    e_cpu = creq && !e_ld;
    chk("starve_cnt", starve_cnt, m_starve);
    chk("cpu_gnt", cpu_gnt, e_cpu);
    chk("ld_gnt",  ld_gnt,  e_ld);
    chk("ramR", ramR, (e_cpu && !cwe) || (e_ld && !lwe));
    chk("ramW", ramW, (e_cpu && cwe) || (e_ld && lwe));
    chk("ram_addr",  ram_addr,  e_cpu ? caddr : (e_ld ? laddr : '0));
    chk("ram_wdata", ram_wdata, e_cpu ? cwd : (e_ld ? lwd : '0));
    nr.kind = 0;
    nr.data = '0;
    if (e_cpu) begin
      if (cwe) model_mem[caddr[7:2]] = cwd;
      else begin nr.kind = 1; nr.data = model_mem[caddr[7:2]]; end
    end else if (e_ld) begin
      if (lwe) model_mem[laddr[7:2]] = lwd;
      else begin nr.kind = 2; nr.data = model_mem[laddr[7:2]]; end
    end
    exp_q.push_back(nr);
    if (!lreq || e_ld) m_starve = 0;
    else if (m_starve < MW) m_starve++;
    who = e_cpu ? 1 : (e_ld ? 2 : 0);
    cyc_no++;
    $display("cyc %0d: creq=%0b cwe=%0b ca=%h lreq=%0b lwe=%0b la=%h -> grant=%s starve=%0d",
             cyc_no, creq, cwe, caddr, lreq, lwe, laddr,
             (who == 1) ? "C" : ((who == 2) ? "L" : "-"), starve_cnt);
  endtask

  // Assert reset (optionally with a CPU read still requested), hold, release.
  task automatic do_reset(input int hold, input logic keep_cpu);
    reset = 1'b0;
    cpu_req = keep_cpu; cpu_we = 1'b0; cpu_addr = keep_cpu ? 32'h10 : '0; cpu_wdata = '0;
    ld_req = keep_cpu; ld_we = 1'b0; ld_addr = keep_cpu ? 32'h4 : '0; ld_wdata = '0;
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_ld_gnt", ld_gnt, 1'b0);
    chk("rst_ramR", ramR, 1'b0);
    chk("rst_ramW", ramW, 1'b0);
    chk("rst_ram_addr", ram_addr, '0);
    chk("rst_starve", starve_cnt, 4'd0);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    repeat (hold) @(posedge clock);
    @(negedge clock);
    chk("rst_hold_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_hold_ld_rvalid", ld_rvalid, 1'b0);
    chk("rst_hold_ramR", ramR, 1'b0);
    cpu_req = 1'b0; ld_req = 1'b0; cpu_addr = '0; ld_addr = '0;
    reset = 1'b1;
    m_starve = 0;
    exp_q.delete();
    exp_q.push_back('{kind: 0, data: '0});
    $display("reset released at cyc %0d", cyc_no);
  endtask

  initial begin
    int    who;
    int    waited;
    string pat;
    for (int i = 0; i < 64; i++) begin
      ram[i] = '0;
      model_mem[i] = '0;
    end
    ram[0] = 32'h11; model_mem[0] = 32'h11;
    ram[1] = 32'h22; model_mem[1] = 32'h22;
    #1;
    do_reset(2, 1'b0);

    // 1: CPU write then read back
    cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, who);
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, who);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, who);

    // 2: sustained contention, reads from both sides
    pat = "CCCCLCCCCL";
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0, who);
      chk("t2_seq", who, (pat[i] == "L") ? 2 : 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, who);

    // 3: alternating single-cycle reads, no cross-routing
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) cyc(1, 0, 32'h0, 0, 0, 0, 0, 0, who);
      else            cyc(0, 0, 0, 0, 1, 0, 32'h4, 0, who);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, who);

    // 4: loader write with CPU idle, then CPU reads it back
    cyc(0, 0, 0, 0, 1, 1, 32'h8, 32'hA5A5A5A5, who);
    cyc(1, 0, 32'h8, 0, 0, 0, 0, 0, who);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, who);

    // 5: CPU read granted, reset asserted before the response edge
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, who);
    do_reset(2, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, who);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, who);

    // 6: loader gives up after 3 denied cycles, then must wait afresh
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0, who);
    cyc(1, 0, 32'h0, 0, 0, 0, 0, 0, who);
    waited = 0;
    who = 0;
    while (who != 2 && waited < 12) begin
      cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0, who);
      waited++;
    end
    chk("t6_ld_wait", waited, MW + 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, who);

    // Random mix to exercise the pipelined response path
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] a1, a2;
      a1 = N'($urandom_range(0, 15)) << 2;
      a2 = N'($urandom_range(0, 15)) << 2;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a1, $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a2, $urandom, who);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, who);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, who);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
